// File: rtl/pcg2_arbiter_if.sv
// Requester-side bus of pcg2_arbiter: seeding control, draw requests,
// one-hot grants and the granted random word.
// The arbiter takes the slave modport; requesters take the master modport.
interface pcg2_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 128
);
    logic [WIDTH-1:0]   seed2;
    logic               reseed_req;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   random_out;
    logic               ready;
    logic [31:0]        draw_count;

    modport master (
        output seed2,
        output reseed_req,
        output req,
        input  gnt,
        input  random_out,
        input  ready,
        input  draw_count
    );

    modport slave (
        input  seed2,
        input  reseed_req,
        input  req,
        output gnt,
        output random_out,
        output ready,
        output draw_count
    );
endinterface

// File: rtl/pcg2_arbiter.sv
// pcg2_arbiter: sequences seeding, pipeline flush and warm-up discard of one free-running
// pcg2 core, then shares the core's output stream among NUM_REQ requesters.
// Requesters are served round-robin. Each core word goes to at most one requester.
// Optional feature: define PCG2_ARB_STATS_EN to enable the 32-bit draw_count statistic.
// Without the macro, draw_count is tied to zero.
module pcg2_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned WARMUP   = 8
) (
    input  logic               clk,
    input  logic               rst,
    pcg2_arbiter_if.slave      bus,
    output logic               core_rst,
    output logic [WIDTH-1:0]   core_seed,
    input  logic [WIDTH-1:0]   core_data
);

    // One counter serves both FLUSH and WARM, so size it for the longer phase.
    localparam int unsigned CntMax = (PIPE_LAT > WARMUP) ? PIPE_LAT : WARMUP;
    localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
    localparam int unsigned PtrW   = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

    localparam logic [CntW-1:0] FlushLast = CntW'(PIPE_LAT - 1);
    localparam logic [CntW-1:0] WarmLast  = CntW'(WARMUP - 1);
    localparam logic [PtrW-1:0] PtrInit   = PtrW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StSeed,
        StFlush,
        StWarm,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   seed_q;
    logic [PtrW-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [WIDTH-1:0]   data_q;

    logic               found;
    logic [PtrW-1:0]    winner;
    logic [PtrW-1:0]    idx;
    logic               grant_en;
    logic [NUM_REQ-1:0] gnt_onehot;

    // State register and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSeed;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: SEED -> FLUSH -> WARM -> RUN. Only RUN reacts to reseed_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StSeed: begin
                state_d = StFlush;
                cnt_d   = '0;
            end
            StFlush: begin
                if (cnt_q == FlushLast) begin
                    cnt_d   = '0;
                    state_d = (WARMUP == 0) ? StRun : StWarm;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWarm: begin
                if (cnt_q == WarmLast) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (bus.reseed_req) begin
                    state_d = StSeed;
                end
            end
            default: begin
                state_d = StSeed;
                cnt_d   = '0;
            end
        endcase
    end

    // Latched seed: sampled during reset and on a reseed accepted in RUN.
    // seed2 is ignored at all other times.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= bus.seed2;
        end else if (state_q == StRun && bus.reseed_req) begin
            seed_q <= bus.seed2;
        end
    end

    // Round-robin search that starts one past the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = PtrW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant only in RUN with no reseed pending. The current core word goes to the winner.
    always_comb begin
        grant_en   = (state_q == StRun) && !bus.reseed_req && found;
        gnt_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner;
    end

    // Registered grant, granted word and round-robin pointer.
    // An unclaimed word is dropped, and random_out is zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            data_q   <= '0;
            rr_ptr_q <= PtrInit;
        end else if (grant_en) begin
            gnt_q    <= gnt_onehot;
            data_q   <= core_data;
            rr_ptr_q <= winner;
        end else begin
            gnt_q  <= '0;
            data_q <= '0;
        end
    end

`ifdef PCG2_ARB_STATS_EN
    logic [31:0] draw_q;

    // Count delivered words. Clear on reset and whenever a new seeding sequence starts.
    always_ff @(posedge clk) begin
        if (rst || state_d == StSeed) begin
            draw_q <= '0;
        end else if (|gnt_q) begin
            draw_q <= draw_q + 32'd1;
        end
    end

    assign bus.draw_count = draw_q;
`else
    assign bus.draw_count = 32'd0;
`endif

    assign bus.gnt        = gnt_q;
    assign bus.random_out = data_q;
    assign bus.ready      = (state_q == StRun);
    assign core_rst       = (state_q == StSeed);
    assign core_seed      = seed_q;

endmodule

// File: tb/tb_pcg2_arbiter.sv
// Testbench for pcg2_arbiter with a behavioural two-stage pcg2-like core.
// Expected grants and words go into a queue when requests are driven and are compared one
// cycle later.
module tb_pcg2_arbiter;

    localparam int unsigned NReq  = 4;
    localparam int unsigned Width = 128;
    localparam logic [127:0] Mul  = 128'h2360ED051FC65DA44385DF649FCCF645;
    localparam logic [127:0] Inc  = 128'h5851F42D4C957F2D14057B7EF767814F;

    typedef struct packed {
        logic [NReq-1:0]  g;
        logic [Width-1:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core_rst;
    logic [Width-1:0] core_seed;
    logic [Width-1:0] core_data = '0;
    logic [Width-1:0] lcg = '0;

    int   checks = 0;
    int   errors = 0;
    int   tb_ptr = NReq - 1;
    exp_t sb[$];

    pcg2_arbiter_if #(.NUM_REQ(NReq), .WIDTH(Width)) bus ();

    pcg2_arbiter #(
        .NUM_REQ (NReq),
        .WIDTH   (Width),
        .PIPE_LAT(2),
        .WARMUP  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .core_rst (core_rst),
        .core_seed(core_seed),
        .core_data(core_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] perm(input logic [127:0] s);
        logic [63:0] x;
        x = s[127:64] ^ s[63:0];
        return {x ^ (x >> 17), {x[30:0], x[63:31]}};
    endfunction

    // Core stand-in: LCG register followed by a registered permutation.
    always @(posedge clk) begin
        lcg       <= core_rst ? core_seed : lcg * Mul + Inc;
        core_data <= perm(lcg);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: returns the winning index, or -1 if nothing is requested.
    function automatic int pick(input int ptr, input logic [NReq-1:0] r);
        int j;
        for (int k = 1; k <= int'(NReq); k++) begin
            j = (ptr + k) % int'(NReq);
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // Drive req during RUN and push the outcome expected one cycle later.
    task automatic issue(input logic [NReq-1:0] r);
        exp_t e;
        int   w;
        bus.req = r;
        w = pick(tb_ptr, r);
        if (w >= 0) begin
            e.g    = NReq'(1) << w;
            e.d    = core_data;
            tb_ptr = w;
        end else begin
            e.g = '0;
            e.d = '0;
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        bus.seed2 = 128'h1;
        bus.req = '0;
        bus.reseed_req = 1'b0;
        cyc();
        rst = 1'b0;
        tb_ptr = NReq - 1;
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_core_rst got %0b want 1", core_rst);
        end
        checks++;
        if (bus.ready !== 1'b0 || bus.gnt !== '0 || bus.random_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%0b gnt=%b rnd=%h want 0/0/0",
                     bus.ready, bus.gnt, bus.random_out);
        end
        checks++;
        if (bus.draw_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_draw_count got %0d want 0", bus.draw_count);
        end
        checks++;
        if (core_seed !== 128'h1) begin
            errors++;
            $display("FAIL reset_core_seed got %h want 1", core_seed);
        end
        cyc();
        checks++;
        if (core_rst !== 1'b0) begin
            errors++;
            $display("FAIL core_rst_one_cycle got %0b want 0", core_rst);
        end
        wait_ready(n);
        checks++;
        if (n + 1 !== 11) begin
            errors++;
            $display("FAIL ready_latency got %0d want 11", n + 1);
        end
    endtask

    task automatic test_all_req();
        exp_t e;
        logic [NReq-1:0] seq [8];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 9; i++) begin
            issue(i < 8 ? 4'b1111 : 4'b0000);
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== e.g || (i < 8 && bus.gnt !== seq[i])) begin
                errors++;
                $display("FAIL all_req_gnt[%0d] got %b want %b", i, bus.gnt, e.g);
            end
            checks++;
            if (bus.random_out !== e.d) begin
                errors++;
                $display("FAIL all_req_word[%0d] got %h want %h", i, bus.random_out, e.d);
            end
        end
    endtask

    task automatic test_lone();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(i < 5 ? 4'b0100 : 4'b0000);
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== e.g || bus.random_out !== e.d) begin
                errors++;
                $display("FAIL lone[%0d] gnt=%b rnd=%h want gnt=%b rnd=%h",
                         i, bus.gnt, bus.random_out, e.g, e.d);
            end
        end
    endtask

    task automatic test_reseed();
        exp_t e;
        int n;
        logic [Width-1:0] first [2];
        bus.req = '0;
        bus.seed2 = 128'hBEEF;
        cyc();
        checks++;
        if (core_seed !== 128'h1) begin
            errors++;
            $display("FAIL seed_unsampled got %h want 1", core_seed);
        end
        for (int r = 0; r < 2; r++) begin
            bus.seed2 = 128'hDEAD;
            bus.reseed_req = 1'b1;
            bus.req = 4'b1111;
            cyc();
            bus.reseed_req = 1'b0;
            bus.req = '0;
            checks++;
            if (bus.gnt !== '0 || core_rst !== 1'b1 || bus.ready !== 1'b0) begin
                errors++;
                $display("FAIL reseed_enter gnt=%b core_rst=%0b ready=%0b want 0/1/0",
                         bus.gnt, core_rst, bus.ready);
            end
            checks++;
            if (core_seed !== 128'hDEAD) begin
                errors++;
                $display("FAIL reseed_core_seed got %h want dead", core_seed);
            end
            wait_ready(n);
            checks++;
            if (n !== 11) begin
                errors++;
                $display("FAIL reseed_ready_latency got %0d want 11", n);
            end
            issue(4'b1111);
            cyc();
            bus.req = '0;
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== e.g || bus.random_out !== e.d) begin
                errors++;
                $display("FAIL reseed_first_word gnt=%b rnd=%h want gnt=%b rnd=%h",
                         bus.gnt, bus.random_out, e.g, e.d);
            end
            first[r] = bus.random_out;
        end
        checks++;
        if (first[1] !== first[0]) begin
            errors++;
            $display("FAIL reseed_repeatable got %h want %h", first[1], first[0]);
        end
    endtask

    task automatic test_stats();
        exp_t e;
        int n;
        logic [31:0] want;
`ifdef PCG2_ARB_STATS_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        bus.reseed_req = 1'b1;
        cyc();
        bus.reseed_req = 1'b0;
        wait_ready(n);
        checks++;
        if (n !== 11 || bus.draw_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_start ready_wait=%0d draw=%0d want 11/0", n, bus.draw_count);
        end
        for (int i = 0; i < 6; i++) begin
            issue(i < 5 ? 4'b0001 : 4'b0000);
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== e.g || bus.random_out !== e.d) begin
                errors++;
                $display("FAIL stats_grant[%0d] gnt=%b rnd=%h want gnt=%b rnd=%h",
                         i, bus.gnt, bus.random_out, e.g, e.d);
            end
        end
        cyc();
        checks++;
        if (bus.draw_count !== want) begin
            errors++;
            $display("FAIL draw_count got %0d want %0d", bus.draw_count, want);
        end
        bus.reseed_req = 1'b1;
        cyc();
        bus.reseed_req = 1'b0;
        checks++;
        if (bus.draw_count !== 32'd0) begin
            errors++;
            $display("FAIL draw_count_clear got %0d want 0", bus.draw_count);
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int n;
        // Five cycles after SEED the core is still in warm-up.
        for (int i = 0; i < 5; i++) cyc();
        bus.seed2 = 128'h1;
        bus.req = 4'b1111;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tb_ptr = NReq - 1;
        checks++;
        if (bus.gnt !== '0 || bus.ready !== 1'b0 || core_rst !== 1'b1 || core_seed !== 128'h1) begin
            errors++;
            $display("FAIL rst_mid_warm gnt=%b ready=%0b core_rst=%0b seed=%h want 0/0/1/1",
                     bus.gnt, bus.ready, core_rst, core_seed);
        end
        wait_ready(n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL rst_mid_warm_ready got %0d want 11", n);
        end
        for (int i = 0; i < 2; i++) begin
            issue(4'b1111);
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== e.g || bus.random_out !== e.d) begin
                errors++;
                $display("FAIL rst_mid_run_pre[%0d] gnt=%b rnd=%h want gnt=%b rnd=%h",
                         i, bus.gnt, bus.random_out, e.g, e.d);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req = '0;
        tb_ptr = NReq - 1;
        sb.delete();
        checks++;
        if (bus.gnt !== '0 || bus.random_out !== '0 || bus.ready !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run gnt=%b rnd=%h ready=%0b core_rst=%0b want 0/0/0/1",
                     bus.gnt, bus.random_out, bus.ready, core_rst);
        end
        checks++;
        if (bus.draw_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_run_draw got %0d want 0", bus.draw_count);
        end
    endtask

    initial begin
        bus.seed2 = '0;
        bus.req = '0;
        bus.reseed_req = 1'b0;
        test_reset();
        test_all_req();
        test_lone();
        test_reseed();
        test_stats();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
